// File: rtl/reg_file_8x16.sv
// ---------------------------------------------------------------------------
// reg_file_8x16
//
// Eight-entry register file with one write port and two registered read
// ports. Every register r0..r7 is writable; none is hardwired. Each read port
// picks its register through a per-bit 8:1 mux steered by its raddr, and the
// selected words are captured into output flops so read data appears one
// edge after the request.
//
// Optional feature (compile-time macro REG_FILE_BYPASS_EN):
//   defined   - a write and a read of the same index in the same cycle
//               return the new wdata on the matching read port(s).
//   undefined - the same collision returns the old register contents; the
//               new value is seen from the next read onward.
//
// Ports:
//   clk      in   rising-edge clock
//   reset    in   asynchronous active-high reset (clears registers + outputs)
//   Enable   in   block enable; gates all writes and reads
//   we       in   write request
//   waddr    in   [2:0] write register index
//   wdata    in   [WIDTH-1:0] write data
//   re       in   read request for both read ports
//   raddr_a  in   [2:0] read index / mux select for port A
//   raddr_b  in   [2:0] read index / mux select for port B
//   rdata_a  out  [WIDTH-1:0] registered read data, port A
//   rdata_b  out  [WIDTH-1:0] registered read data, port B
//   rvalid   out  high for exactly the cycle after an accepted read
// ---------------------------------------------------------------------------
module reg_file_8x16 #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Enable,
    input  logic             we,
    input  logic [2:0]       waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [2:0]       raddr_a,
    input  logic [2:0]       raddr_b,
    output logic [WIDTH-1:0] rdata_a,
    output logic [WIDTH-1:0] rdata_b,
    output logic             rvalid
);

    localparam int NUM_REGS = 8;

    logic [WIDTH-1:0] regs_q [NUM_REGS];
    logic [WIDTH-1:0] regs_d [NUM_REGS];
    logic [WIDTH-1:0] rdata_a_q, rdata_a_d;
    logic [WIDTH-1:0] rdata_b_q, rdata_b_d;
    logic             rvalid_q, rvalid_d;

    logic             write_fire;
    logic             read_fire;
    logic [WIDTH-1:0] mux_a;
    logic [WIDTH-1:0] mux_b;
    logic [WIDTH-1:0] fwd_a;
    logic [WIDTH-1:0] fwd_b;

    assign write_fire = Enable & we;
    assign read_fire  = Enable & re;

    // Bit-slice read muxes: each output bit is an independent 8:1 mux whose
    // select is the port's raddr, so code 0 lands on r0 and code 7 on r7.
    always_comb begin
        mux_a = '0;
        mux_b = '0;
        for (int b = 0; b < WIDTH; b++) begin
            mux_a[b] = regs_q[raddr_a][b];
            mux_b[b] = regs_q[raddr_b][b];
        end
    end

    // Collision handling between the write port and each read port.
`ifdef REG_FILE_BYPASS_EN
    always_comb begin
        fwd_a = mux_a;
        fwd_b = mux_b;
        if (write_fire && (waddr == raddr_a)) begin
            fwd_a = wdata;
        end
        if (write_fire && (waddr == raddr_b)) begin
            fwd_b = wdata;
        end
    end
`else
    // Without bypass the read sees the register contents before this edge.
    always_comb begin
        fwd_a = mux_a;
        fwd_b = mux_b;
    end
`endif

    // Next-state logic: registers and read data hold unless the enabled
    // write/read request targets them.
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            regs_d[i] = regs_q[i];
        end
        rdata_a_d = rdata_a_q;
        rdata_b_d = rdata_b_q;
        rvalid_d  = read_fire;

        if (write_fire) begin
            regs_d[waddr] = wdata;
        end
        if (read_fire) begin
            rdata_a_d = fwd_a;
            rdata_b_d = fwd_b;
        end
    end

    // State flops; reset clears everything immediately, discarding any
    // operation that was set up for the coming edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
            rdata_a_q <= '0;
            rdata_b_q <= '0;
            rvalid_q  <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
            rdata_a_q <= rdata_a_d;
            rdata_b_q <= rdata_b_d;
            rvalid_q  <= rvalid_d;
        end
    end

    assign rdata_a = rdata_a_q;
    assign rdata_b = rdata_b_q;
    assign rvalid  = rvalid_q;

endmodule

// File: tb/tb_reg_file_8x16.sv
// ---------------------------------------------------------------------------
// tb_reg_file_8x16
//
// Directed and randomized checks for reg_file_8x16. A behavioural model
// (a plain array of eight words plus the expected output registers) predicts
// every cycle's read data; directed steps also compare against literal values.
// Build with REG_FILE_BYPASS_EN defined to check the bypass variant.
// ---------------------------------------------------------------------------
module tb_reg_file_8x16;

    localparam int WIDTH = 16;

`ifdef REG_FILE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic             clk;
    logic             reset;
    logic             Enable;
    logic             we;
    logic [2:0]       waddr;
    logic [WIDTH-1:0] wdata;
    logic             re;
    logic [2:0]       raddr_a;
    logic [2:0]       raddr_b;
    logic [WIDTH-1:0] rdata_a;
    logic [WIDTH-1:0] rdata_b;
    logic             rvalid;

    int total;
    int bad;

    // Reference model state
    logic [WIDTH-1:0] mem [8];
    logic [WIDTH-1:0] exp_a;
    logic [WIDTH-1:0] exp_b;
    logic             exp_v;

    reg_file_8x16 #(.WIDTH(WIDTH)) dut (
        .clk     (clk),
        .reset   (reset),
        .Enable  (Enable),
        .we      (we),
        .waddr   (waddr),
        .wdata   (wdata),
        .re      (re),
        .raddr_a (raddr_a),
        .raddr_b (raddr_b),
        .rdata_a (rdata_a),
        .rdata_b (rdata_b),
        .rvalid  (rvalid)
    );

    // 10 time-unit clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [WIDTH-1:0] obs,
                            input logic [WIDTH-1:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Compare all outputs against the model's prediction.
    task automatic checkOutput(input string tag);
        checkVal({tag, ".rdata_a"}, rdata_a, exp_a);
        checkVal({tag, ".rdata_b"}, rdata_b, exp_b);
        checkVal({tag, ".rvalid"}, {{(WIDTH-1){1'b0}}, rvalid}, {{(WIDTH-1){1'b0}}, exp_v});
    endtask

    task automatic modelReset();
        for (int i = 0; i < 8; i++) mem[i] = '0;
        exp_a = '0;
        exp_b = '0;
        exp_v = 1'b0;
    endtask

    // Drive one cycle of inputs at the falling edge, let the rising edge take
    // them, advance the model, and leave time at #1 after the edge for checks.
    task automatic applyStimulus(input logic en, input logic w, input logic [2:0] wa,
                                 input logic [WIDTH-1:0] wd, input logic r,
                                 input logic [2:0] ra, input logic [2:0] rb);
        @(negedge clk);
        Enable  = en;
        we      = w;
        waddr   = wa;
        wdata   = wd;
        re      = r;
        raddr_a = ra;
        raddr_b = rb;
        @(posedge clk);
        if (en && r) begin
            exp_a = mem[ra];
            exp_b = mem[rb];
            if (BYPASS && en && w) begin
                if (wa == ra) exp_a = wd;
                if (wa == rb) exp_b = wd;
            end
            exp_v = 1'b1;
        end else begin
            exp_v = 1'b0;
        end
        if (en && w) mem[wa] = wd;
        #1;
    endtask

    task automatic idle();
        applyStimulus(1'b0, 1'b0, 3'd0, '0, 1'b0, 3'd0, 3'd0);
    endtask

    initial begin
        logic [WIDTH-1:0] v;
        logic [WIDTH-1:0] w;
        total   = 0;
        bad     = 0;
        Enable  = 1'b0;
        we      = 1'b0;
        waddr   = '0;
        wdata   = '0;
        re      = 1'b0;
        raddr_a = '0;
        raddr_b = '0;
        modelReset();
        $display("[TB] start, bypass=%0d", BYPASS);

        // Power-on reset
        reset = 1'b1;
        #12;
        checkOutput("por");
        @(negedge clk);
        reset = 1'b0;

        // Preload every register with all ones and read some back
        for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b1, 3'(i), 16'hFFFF, 1'b0, 3'd0, 3'd0);
        applyStimulus(1'b1, 1'b0, 3'd0, '0, 1'b1, 3'd0, 3'd7);
        checkVal("preload.a", rdata_a, 16'hFFFF);
        checkOutput("preload");

        // Reset pulse between edges: outputs clear without a clock edge
        @(negedge clk);
        Enable = 1'b0;
        re     = 1'b0;
        we     = 1'b0;
        #1;
        reset = 1'b1;
        #1;
        modelReset();
        checkVal("rst_async.a", rdata_a, 16'h0000);
        checkOutput("rst_async");
        @(posedge clk);
        #1;
        checkOutput("rst_hold");
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, 1'b0, 3'd0, '0, 1'b1, 3'(i), 3'(7 - i));
            checkVal("rst_clear.a", rdata_a, 16'h0000);
            checkVal("rst_clear.v", {15'd0, rvalid}, 16'h0001);
            checkOutput("rst_clear");
        end

        // Write/read walk
        for (int i = 0; i < 8; i++) begin
            v = 16'h1111 * 16'(i);
            applyStimulus(1'b1, 1'b1, 3'(i), v, 1'b0, 3'd0, 3'd0);
        end
        for (int i = 0; i < 8; i++) begin
            v = 16'h1111 * 16'(i);
            w = 16'h1111 * 16'(7 - i);
            applyStimulus(1'b1, 1'b0, 3'd0, '0, 1'b1, 3'(i), 3'(7 - i));
            checkVal("walk.a", rdata_a, v);
            checkVal("walk.b", rdata_b, w);
            checkVal("walk.v", {15'd0, rvalid}, 16'h0001);
        end
        idle();
        checkVal("walk_end.v", {15'd0, rvalid}, 16'h0000);

        // Enable gating blocks a write
        applyStimulus(1'b0, 1'b1, 3'd3, 16'hDEAD, 1'b1, 3'd3, 3'd3);
        checkOutput("gate_noread");
        applyStimulus(1'b1, 1'b0, 3'd0, '0, 1'b1, 3'd3, 3'd3);
        checkVal("gate.a", rdata_a, 16'h3333);
        checkVal("gate.b", rdata_b, 16'h3333);

        // Same-cycle collision on r5
        applyStimulus(1'b1, 1'b1, 3'd5, 16'h00AA, 1'b0, 3'd0, 3'd0);
        applyStimulus(1'b1, 1'b1, 3'd5, 16'h5555, 1'b1, 3'd5, 3'd0);
        checkVal("collide.a", rdata_a, BYPASS ? 16'h5555 : 16'h00AA);
        checkOutput("collide");
        applyStimulus(1'b1, 1'b0, 3'd0, '0, 1'b1, 3'd5, 3'd5);
        checkVal("collide_next.a", rdata_a, 16'h5555);
        checkVal("collide_next.b", rdata_b, 16'h5555);

        // Hold behaviour across idle cycles, with writes still going on
        applyStimulus(1'b1, 1'b1, 3'd1, 16'h1234, 1'b0, 3'd0, 3'd0);
        applyStimulus(1'b1, 1'b0, 3'd0, '0, 1'b1, 3'd1, 3'd1);
        checkVal("hold_rd.a", rdata_a, 16'h1234);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 1'b1, 3'(i + 2), 16'h0F0F, 1'b0, 3'd6, 3'd6);
            checkVal("hold.a", rdata_a, 16'h1234);
            checkVal("hold.v", {15'd0, rvalid}, 16'h0000);
        end

        // Reset in the middle of a write of BEEF to r2
        @(negedge clk);
        Enable  = 1'b1;
        we      = 1'b1;
        waddr   = 3'd2;
        wdata   = 16'hBEEF;
        re      = 1'b1;
        raddr_a = 3'd1;
        raddr_b = 3'd1;
        #2;
        reset = 1'b1;
        #1;
        modelReset();
        checkVal("midrst.a", rdata_a, 16'h0000);
        checkOutput("midrst");
        @(posedge clk);
        #1;
        checkOutput("midrst_edge");
        @(negedge clk);
        Enable = 1'b0;
        we     = 1'b0;
        re     = 1'b0;
        reset  = 1'b0;
        applyStimulus(1'b1, 1'b0, 3'd0, '0, 1'b1, 3'd2, 3'd1);
        checkVal("midrst_r2.a", rdata_a, 16'h0000);
        checkOutput("midrst_r2");

        // Randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            applyStimulus(($urandom_range(0, 7) != 0), $urandom_range(0, 1) == 1,
                          3'($urandom_range(0, 7)), 16'($urandom),
                          $urandom_range(0, 2) != 0,
                          3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
            checkOutput("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/reg_file_8x16.md
REG_FILE_8X16 -- requirements
Module: reg_file_8x16

Interface
REQ-001 SHALL have parameter WIDTH, default 16: data width of each register and port.
REQ-002 SHALL have one clock and an asynchronous, active-high reset: clk (input, 1, rising-edge clock) and reset (input, 1, async active-high reset).
REQ-003 SHALL have port Enable, input, 1: block enable; gates all writes and reads.
REQ-004 SHALL have port we, input, 1: write request.
REQ-005 SHALL have port waddr, input, 3: write register index 0..7.
REQ-006 SHALL have port wdata, input, WIDTH: write data.
REQ-007 SHALL have port re, input, 1: read request for both read ports.
REQ-008 SHALL have ports raddr_a and raddr_b, input, 3 each: read register indices, doubling as the select codes for the downstream 8:1 bit-slice muxes.
REQ-009 SHALL have ports rdata_a and rdata_b, output, WIDTH each: registered read data.
REQ-010 SHALL have port rvalid, output, 1: rdata_a/rdata_b updated this cycle.

Function
REQ-011 SHALL hold 8 registers of WIDTH bits, r0..r7, all writable; no hardwired register.
REQ-012 Write: Enable=1 and we=1 at a rising clk edge SHALL load wdata into register[waddr]; otherwise all registers SHALL hold.
REQ-013 Read select: each read port SHALL select register[raddr] through a per-bit 8:1 mux; select code 0 maps to r0 and 7 to r7.
REQ-014 Read latency: Enable=1 and re=1 at edge N SHALL capture both selected values into rdata_a/rdata_b, visible after edge N, with rvalid=1 for exactly that cycle.
REQ-015 No read: when Enable=0 or re=0 at an edge, rdata_a/rdata_b SHALL hold their previous values and rvalid SHALL be 0.
REQ-016 Same-address read/write in the same cycle: the result is set by BYPASS_EN (REQ-022/023).
REQ-017 Both read ports addressing the same register SHALL return identical data.
REQ-018 Enable=0 SHALL block writes even when we=1.
REQ-019 No arithmetic, truncation or extension SHALL occur; data SHALL be stored and returned bit-exact at WIDTH.

Reset
REQ-020 reset=1 SHALL immediately, without waiting for clk, clear r0..r7, rdata_a and rdata_b to 0 and rvalid to 0.
REQ-021 A reset asserted mid-operation SHALL discard any write or read in flight; the first operation after reset deasserts SHALL take effect at the first rising edge with reset=0.

Configuration
REQ-022 With macro REG_FILE_BYPASS_EN defined, a same-cycle write and read of the same index SHALL return the new wdata on the matching read port(s).
REQ-023 With REG_FILE_BYPASS_EN undefined, a same-cycle write and read of the same index SHALL return the old register contents; the new value SHALL be readable from the next read onward.

Verification
REQ-024 Reset check: reset pulse with registers preloaded to 16'hFFFF -> all registers, rdata_a and rdata_b read 16'h0000; rvalid=0 during and after reset.
REQ-025 Write/read walk: write 16'h1111*i to ri for i=0..7, then read a=i, b=7-i -> rdata_a=16'h1111*i and rdata_b=16'h1111*(7-i), each one cycle after re, with rvalid=1.
REQ-026 Enable gating: Enable=0, we=1, waddr=3, wdata=16'hDEAD, then read r3 with Enable=1 -> previous r3 value returned, not 16'hDEAD.
REQ-027 Same-cycle collision: r5=16'h00AA; write 16'h5555 to r5 with raddr_a=5 and re=1 in the same cycle -> rdata_a=16'h5555 with REG_FILE_BYPASS_EN, 16'h00AA without it; a following read returns 16'h5555 in both builds.
REQ-028 Async reset mid-write: assert reset between edges during a write of 16'hBEEF to r2 -> outputs go to 0 before the next edge; r2 reads 16'h0000 after reset releases.
REQ-029 Hold behaviour: re=0 for 4 cycles after a read of 16'h1234 -> rdata_a stays 16'h1234 and rvalid stays 0.
